// File: rtl/sparse_zeroskip_pkg.sv
// Shared constants, types and FSM states for the
// structured-sparse zeroskip cmap scheduler.
package sparse_zeroskip_pkg;
    localparam int BIT_NONZERO   = 8;
    localparam int BIT_GROUPSIZE = 16;
    localparam int N             = 8;
    localparam int IDX_W = $clog2(BIT_GROUPSIZE);
    localparam int GID_W = $clog2(N);
    localparam int CNT_W = $clog2(BIT_GROUPSIZE + 1);

    typedef logic [BIT_NONZERO-1:0][IDX_W-1:0] nz_index_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE
    } sched_state_e;
endpackage

// File: rtl/sparse_zeroskip_pos_finder.sv
// Combinational cmap-to-position converter: cascaded
// lowest-set-bit searches plus a full popcount.
module sparse_zeroskip_pos_finder
    import sparse_zeroskip_pkg::*;
(
    input  logic [BIT_GROUPSIZE-1:0] cmap,
    output nz_index_t                nz,
    output logic [CNT_W-1:0]         popcnt
);
    localparam logic [BIT_GROUPSIZE-1:0] ONE = 1;

    logic [BIT_GROUPSIZE-1:0] rem;

    // Each stage takes the lowest remaining set bit, then clears it
    always_comb begin
        rem = cmap;
        nz  = '0;
        for (int k = 0; k < BIT_NONZERO; k++) begin
            for (int i = BIT_GROUPSIZE - 1; i >= 0; i--) begin
                if (rem[i]) nz[k] = IDX_W'(i);
            end
            rem = rem & (rem - ONE);
        end
    end

    // Count every set bit so over-full cmaps are detected too
    always_comb begin
        popcnt = '0;
        for (int i = 0; i < BIT_GROUPSIZE; i++) begin
            popcnt = popcnt + CNT_W'(cmap[i]);
        end
    end
endmodule

// File: rtl/sparse_zeroskip_cmap_scheduler.sv
// Accepts one cmap per tile, registers its nonzero positions
// and issues N group index beats over valid/ready.
module sparse_zeroskip_cmap_scheduler
    import sparse_zeroskip_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         cmap_valid,
    output logic                         cmap_ready,
    input  logic [BIT_GROUPSIZE-1:0]     cmap,
    output logic                         idx_valid,
    input  logic                         idx_ready,
    output logic [BIT_NONZERO*IDX_W-1:0] idx_nz,
    output logic [GID_W-1:0]             idx_group,
    output logic                         idx_last,
    output logic                         idx_err,
    output logic                         err_sticky,
    input  logic                         err_clr,
    output logic                         busy
);
    sched_state_e             state_q;
    sched_state_e             state_d;
    logic [BIT_GROUPSIZE-1:0] cmap_q;
    nz_index_t                idx_q;
    nz_index_t                nz_found;
    logic [CNT_W-1:0]         popcnt;
    logic [GID_W-1:0]         grp_cnt;
    logic                     err_q;
    logic                     err_found;
    logic                     accept;

    sparse_zeroskip_pos_finder u_pos_finder (
        .cmap   (cmap_q),
        .nz     (nz_found),
        .popcnt (popcnt)
    );

    assign err_found = (popcnt != CNT_W'(BIT_NONZERO));
    assign accept    = cmap_valid && cmap_ready;
    assign idx_last  = (grp_cnt == GID_W'(N - 1));
    assign idx_nz    = idx_q;
    assign idx_group = grp_cnt;
    assign idx_err   = err_q;
    assign busy      = (state_q != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs; flush always returns to IDLE
    always_comb begin
        state_d    = state_q;
        cmap_ready = 1'b0;
        idx_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmap_ready = !flush;
                if (cmap_valid && !flush) state_d = LOAD;
            end
            LOAD: begin
                state_d = flush ? IDLE : ISSUE;
            end
            ISSUE: begin
                idx_valid = 1'b1;
                if (flush || (idx_ready && idx_last)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tile datapath: capture cmap, latch positions, count groups
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmap_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            grp_cnt <= '0;
        end else begin
            if (accept) cmap_q <= cmap;
            if (state_q == LOAD) begin
                idx_q <= nz_found;
                err_q <= err_found;
            end
            if (state_q != ISSUE || flush) begin
                grp_cnt <= '0;
            end else if (idx_ready) begin
                grp_cnt <= idx_last ? '0 : grp_cnt + GID_W'(1);
            end
        end
    end

    // Sticky error; a new error beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         err_sticky <= 1'b0;
        else if (state_q == LOAD && err_found) err_sticky <= 1'b1;
        else if (err_clr)                   err_sticky <= 1'b0;
    end
endmodule

// File: doc/sparse_zeroskip_cmap_scheduler.md
Name: sparse_zeroskip_cmap_scheduler

Overview:
- Sequences the zeroskip gather datapath for structured-sparse (BIT_NONZERO-of-BIT_GROUPSIZE) weights.
- Accepts one compression bitmap (cmap) per tile. Converts it to BIT_NONZERO ascending nonzero positions in a registered stage.
- Issues N per-group index beats, one per group sharing that cmap, to the downstream activation-gather unit over valid/ready.
- Flags cmaps that violate the structured-sparsity contract.

Parameters:
- BIT_NONZERO, 8, nonzeros per group.
- BIT_GROUPSIZE, 16, group width in elements.
- N, 8, groups sharing one cmap; must be ≥ 2.
- Derived localparams: IDX_W = $clog2(BIT_GROUPSIZE), GID_W = $clog2(N).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current tile.
- cmap_valid  in  1  cmap offered.
- cmap_ready  out  1  scheduler can accept a cmap.
- cmap  in  BIT_GROUPSIZE  bit i set means element i is nonzero.
- idx_valid  out  1  index beat valid.
- idx_ready  in  1  downstream accepts beat.
- idx_nz  out  BIT_NONZERO×IDX_W  packed absolute nonzero positions, entry 0 lowest.
- idx_group  out  GID_W  group number of this beat, 0..N-1.
- idx_last  out  1  beat is group N-1 of the tile.
- idx_err  out  1  current tile's cmap popcount ≠ BIT_NONZERO.
- err_sticky  out  1  OR of all idx_err since reset or err_clr.
- err_clr  in  1  clears err_sticky.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cmap_q, idx_q, grp_cnt, err_q, err_sticky all 0.
  - idx_valid=0, busy=0, cmap_ready=1 as soon as rst_n deasserts.
- FSM states: IDLE, LOAD, ISSUE.
  - IDLE: cmap_ready=1. When cmap_valid=1, capture cmap into cmap_q and go to LOAD.
  - LOAD: cmap_ready=0, idx_valid=0.
    - Sub-module output latched into idx_q.
    - err_q = (popcount(cmap_q) ≠ BIT_NONZERO).
    - grp_cnt=0; go to ISSUE.
  - ISSUE: idx_valid=1, with idx_nz=idx_q, idx_group=grp_cnt, idx_err=err_q, idx_last=(grp_cnt==N-1).
    - Handshake (idx_valid & idx_ready) with grp_cnt<N-1: grp_cnt+1.
    - Handshake with grp_cnt==N-1: go to IDLE.
    - No handshake: all outputs held stable. Valid never drops without a handshake except on flush or reset.
- Latency and throughput:
  - cmap accepted at edge t gives first beat valid in the cycle after edge t+1.
  - Minimum period is N+2 cycles per cmap. No overlap between tiles.
- Index rule:
  - idx_nz[k] is the bit position of the (k+1)-th set bit of cmap, scanning from LSB.
  - If popcount > BIT_NONZERO, only the lowest BIT_NONZERO set bits are reported.
  - If popcount < BIT_NONZERO, the missing entries are 0.
  - Beats are issued regardless of the error; idx_err marks all N beats of that tile.
- err_sticky:
  - Set in the LOAD cycle when err_q is written 1.
  - err_clr and a set in the same cycle: set wins.
- flush:
  - In LOAD or ISSUE: next state IDLE, idx_valid=0 next cycle, grp_cnt=0. Any beat completing in the flush cycle still counts.
  - In IDLE with cmap_valid: flush wins and the cmap is not accepted (cmap_ready=0 while flush=1).
  - err_sticky is unaffected by flush.
- Reset mid-tile: outputs go to reset values immediately; no partial tile resumes.

Decomposition:
- Shared package sparse_zeroskip_pkg holds:
  - Default constants BIT_NONZERO, BIT_GROUPSIZE, N.
  - IDX_W.
  - Typedef nz_index_t (BIT_NONZERO×IDX_W packed array).
  - State enum sched_state_e {IDLE, LOAD, ISSUE}.
- One combinational sub-module, sparse_zeroskip_pos_finder:
  - cmap in; nz_index_t and popcount out.
  - Implemented as BIT_NONZERO cascaded lowest-set-bit searches, each clearing the found bit.
  - The scheduler holds all registers and the FSM.

Test Plan:
- cmap=16'h0F0F, idx_ready=1 → first beat 2 cycles after accept; idx_nz={0,1,2,3,8,9,10,11}; groups 0..7; idx_last only on group 7; idx_err=0; cmap_ready high again 1 cycle after the last beat.
- cmap=16'h5555 with idx_ready toggling 1,0,1,0 → idx_nz={0,2,4,...,14}; outputs stable while idx_ready=0; exactly 8 handshakes, idx_group increments only on handshakes.
- cmap=16'h0007 → idx_nz={0,1,2,0,0,0,0,0}; idx_err=1 on all 8 beats; err_sticky=1. A following cmap=16'hFF00 gives idx_err=0, idx_nz={8..15}, err_sticky still 1 until err_clr.
- Back-to-back cmaps 16'h00FF then 16'hFF00 held valid → second is accepted only in IDLE after the group-7 handshake of the first; no beat is lost or duplicated.
- flush asserted after group 3 handshake → idx_valid=0 next cycle, busy=0, next cmap restarts at idx_group=0; flush with cmap_valid in IDLE → cmap not accepted.
- rst_n pulsed low mid-ISSUE → idx_valid=0 and busy=0 asynchronously; err_sticky=0; normal operation after release.
